serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes In_A - In_B - Borrow_in, one bit per clock, LSB first.
- One full-subtractor cell is evaluated each cycle, and its borrow is fed back through a register.
- Sits directly upstream of the single-cell full subtractor: sequences operand bits into it and consumes its Difference/Borrow_out each cycle.
- Gives an area-cheap subtract for wide operands, with a Start/Busy/Done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..64).

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- In_A  input  WIDTH  minuend; captured on the accepted Start.
- In_B  input  WIDTH  subtrahend; captured on the accepted Start.
- Borrow_in  input  1  initial borrow; captured on the accepted Start.
- Busy  output  1  high while in SHIFT state.
- Done  output  1  one-cycle pulse when the result is valid.
- Difference  output  WIDTH  registered result; held until the next completion.
- Borrow_out  output  1  final borrow out of the MSB; held with Difference.

Behaviour:
- Reset (Rst_n low, async): state=IDLE; Busy, Done, Difference, Borrow_out, shift registers, borrow register and counter all 0.
- Reset mid-operation aborts the operation. No Done is produced. Outputs return to 0.
- States:
  - IDLE: Start=1 at an edge loads a_sr<=In_A, b_sr<=In_B, br<=Borrow_in, cnt<=0, then goes to SHIFT. Start=0 stays in IDLE.
  - SHIFT: each edge handles bit a=a_sr[0], b=b_sr[0]:
    - d = a^b^br
    - bo = (~a&b) | (~(a^b)&br)
    - res_sr <= {d, res_sr[WIDTH-1:1]}; a_sr and b_sr shift right; br<=bo; cnt<=cnt+1.
    - On the edge with cnt==WIDTH-1: Difference<={d, res_sr[WIDTH-1:1]}, Borrow_out<=bo, then go to DONE.
  - DONE: Done=1 for exactly this one cycle, then unconditionally IDLE.
- Busy=1 exactly in SHIFT. Done=1 exactly in DONE. Both are decoded from registered state.
- Latency: Start accepted at edge t0, Busy high t0..tWIDTH, Done high in cycle tWIDTH..tWIDTH+1. That is WIDTH+1 edges from acceptance to Done, so the next Start is accepted at tWIDTH+2 at the earliest.
- Start while SHIFT or DONE: ignored, with no queuing. Input changes after acceptance have no effect.
- Difference/Borrow_out change only on the completing edge and are stable during Busy (previous result held).
- Arithmetic is unsigned modulo 2^WIDTH. Borrow_out=1 iff In_A < In_B + Borrow_in.
- Counter width: $clog2(WIDTH+1); it cannot wrap within an operation.
- WIDTH=1: a single SHIFT cycle; Done at t2.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined:
  - Adds output port Overflow (1 bit), reset 0, updated with Difference on the completing edge.
  - Overflow = borrow into MSB XOR borrow out of MSB, i.e. signed two's-complement overflow of A-B-Bin.
  - Requires a one-bit register holding br at the MSB step.
- Undefined: no Overflow port, no extra logic. All other behaviour is identical.

Test Plan (WIDTH=8):
- Start with A=0x05, B=0x03, Bin=0 -> Busy 8 cycles, Done 1 cycle later; Difference=0x02, Borrow_out=0.
- A=0x03, B=0x05, Bin=0 -> Difference=0xFE, Borrow_out=1. A=0x00, B=0x00, Bin=1 -> 0xFF, Borrow_out=1.
- A=0xFF, B=0xFF, Bin=0 -> 0x00, Borrow_out=0. Start pulsed every cycle during Busy -> exactly one Done per operation; result unaffected by input changes after acceptance.
- Rst_n low at the 4th Busy cycle -> Busy/Done/Difference/Borrow_out go to 0 immediately; no Done. A new Start after release completes normally.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN: A=0x80, B=0x01, Bin=0 -> 0x7F, Overflow=1, Borrow_out=0; A=0x7F, B=0xFF -> 0x80, Overflow=1, Borrow_out=1.
- Back-to-back: Start held high continuously -> operations accepted every WIDTH+2 cycles, and each result is held until the next Done.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B - Borrow_in), LSB first, one full-subtractor cell per clock.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the signed Overflow output.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] In_A,
   input  logic [WIDTH-1:0] In_B,
   input  logic             Borrow_in,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Difference,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   output logic             Overflow,
`endif
   output logic             Borrow_out
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res_sr;
   logic [WIDTH-1:0]   res_next;
   logic               br;
   logic [CNT_W-1:0]   cnt;
   logic               bit_a;
   logic               bit_b;
   logic               d;
   logic               bo;
   logic               last;

   // Single full-subtractor cell
   always_comb begin
      bit_a = a_sr[0];
      bit_b = b_sr[0];
      d     = bit_a ^ bit_b ^ br;
      bo    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
      last  = (cnt == CNT_W'(WIDTH - 1));
   end

   // Shift-in written this way so WIDTH=1 needs no empty slice
   always_comb begin
      res_next            = res_sr >> 1;
      res_next[WIDTH-1]   = d;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (Start) state_next = SHIFT;
         SHIFT:   if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      unique case (state)
         SHIFT:   Busy = 1'b1;
         DONE:    Done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         br         <= 1'b0;
         cnt        <= '0;
         Difference <= '0;
         Borrow_out <= 1'b0;
      end else begin
         if (state == IDLE && Start) begin
            a_sr <= In_A;
            b_sr <= In_B;
            br   <= Borrow_in;
            cnt  <= '0;
         end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            br     <= bo;
            cnt    <= cnt + 1'b1;
            if (last) begin
               Difference <= res_next;
               Borrow_out <= bo;
            end
         end
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   // br at the MSB step is the borrow into the MSB
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Overflow <= 1'b0;
      end else if (state == SHIFT && last) begin
         Overflow <= br ^ bo;
      end
   end
`endif

endmodule
